// File: rtl/riscv_core_if.sv
// Instruction-fetch and data-access buses between the core and its memories.
interface riscv_core_if;
   logic [31:0] instruction_address;
   logic [31:0] instruction_data;
   logic [31:0] data_address;
   logic [1:0]  data_width;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        data_read;
   logic        data_write;

   // Core side.
   modport master (
      output instruction_address,
      input  instruction_data,
      output data_address,
      output data_width,
      input  data_in,
      output data_out,
      output data_read,
      output data_write
   );

   // Memory side.
   modport slave (
      input  instruction_address,
      output instruction_data,
      input  data_address,
      input  data_width,
      output data_in,
      input  data_out,
      input  data_read,
      input  data_write
   );
endinterface

// File: rtl/riscv_core.sv
// Single-cycle RV32I integer core: one instruction fetched, executed and retired per clock.
module riscv_core #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic         clock,
   input  logic         reset,
   riscv_core_if.master bus
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   logic [XLEN-1:0] pc, pc_next, instr;
   logic [XLEN-1:0] regs [NREG];
   logic [6:0]      opcode;
   logic [4:0]      rd, rs1, rs2, shamt;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] rs1_val, rs2_val, alu_b, alu_y, load_val, link, jalr_sum;
   logic            take_branch, wr_en, rd_strobe, wr_strobe, load_ok, store_ok;
   logic [XLEN-1:0] wr_data;

   assign instr  = bus.instruction_data;
   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
   assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
   assign link     = pc + 32'd4;
   assign jalr_sum = rs1_val + imm_i;

   // funct3 values 3, 6, 7 have no load; 3 and above have no store.
   assign load_ok  = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
   assign store_ok = !funct3[2] && (funct3[1:0] != 2'b11);

   // Shared ALU for register-register and register-immediate operations.
   always_comb begin
      alu_b = (opcode == OP_REG) ? rs2_val : imm_i;
      shamt = alu_b[4:0];
      case (funct3)
         3'd0:    alu_y = (opcode == OP_REG && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
         3'd1:    alu_y = rs1_val << shamt;
         3'd2:    alu_y = {31'b0, $signed(rs1_val) < $signed(alu_b)};
         3'd3:    alu_y = {31'b0, rs1_val < alu_b};
         3'd4:    alu_y = rs1_val ^ alu_b;
         3'd5:    alu_y = instr[30] ? XLEN'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
         3'd6:    alu_y = rs1_val | alu_b;
         default: alu_y = rs1_val & alu_b;
      endcase
   end

   // Branch condition; funct3 values 2 and 3 are never taken.
   always_comb begin
      case (funct3)
         3'd0:    take_branch = (rs1_val == rs2_val);
         3'd1:    take_branch = (rs1_val != rs2_val);
         3'd4:    take_branch = $signed(rs1_val) <  $signed(rs2_val);
         3'd5:    take_branch = $signed(rs1_val) >= $signed(rs2_val);
         3'd6:    take_branch = rs1_val <  rs2_val;
         3'd7:    take_branch = rs1_val >= rs2_val;
         default: take_branch = 1'b0;
      endcase
   end

   // Memory already right-aligned the load data; only width masking and extension remain.
   always_comb begin
      case (funct3)
         3'd0:    load_val = {{24{bus.data_in[7]}}, bus.data_in[7:0]};
         3'd1:    load_val = {{16{bus.data_in[15]}}, bus.data_in[15:0]};
         3'd4:    load_val = {24'b0, bus.data_in[7:0]};
         3'd5:    load_val = {16'b0, bus.data_in[15:0]};
         default: load_val = bus.data_in;
      endcase
   end

   // Instruction control: next PC, register write-back and bus strobes.
   always_comb begin
      pc_next   = link;
      wr_en     = 1'b0;
      wr_data   = '0;
      rd_strobe = 1'b0;
      wr_strobe = 1'b0;
      case (opcode)
         OP_LUI:   begin wr_en = 1'b1; wr_data = imm_u; end
         OP_AUIPC: begin wr_en = 1'b1; wr_data = pc + imm_u; end
         OP_JAL:   begin wr_en = 1'b1; wr_data = link; pc_next = pc + imm_j; end
         OP_JALR: begin
            if (funct3 == 3'd0) begin
               wr_en   = 1'b1;
               wr_data = link;
               pc_next = {jalr_sum[31:1], 1'b0};
            end
         end
         OP_BRANCH: if (take_branch) pc_next = pc + imm_b;
         OP_LOAD: begin
            if (load_ok) begin
               rd_strobe = 1'b1;
               wr_en     = 1'b1;
               wr_data   = load_val;
            end
         end
         OP_STORE: wr_strobe = store_ok;
         OP_IMM, OP_REG: begin wr_en = 1'b1; wr_data = alu_y; end
         default: ;
      endcase
   end

   assign bus.instruction_address = pc;
   assign bus.data_address = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
   assign bus.data_width   = (rd_strobe || wr_strobe) ? funct3[1:0] : 2'd2;
   assign bus.data_out     = rs2_val;
   assign bus.data_read    = rd_strobe & reset;
   assign bus.data_write   = wr_strobe & reset;

   // PC and register file update; reset discards the instruction in flight.
   always_ff @(posedge clock) begin
      if (!reset) begin
         pc <= RESET_VECTOR;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         pc <= pc_next;
         if (wr_en && rd != 5'd0) regs[rd] <= wr_data;
      end
   end

endmodule

// File: tb/tb_riscv_core.sv
// Scoreboard bench for riscv_core: directed programs, expected PCs and bus events queued, checked by a monitor.
module tb_riscv_core;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic        is_write;
      logic [31:0] addr;
      logic [1:0]  width;
      logic [31:0] data;
   } bus_ev_t;

   logic        clock;
   logic        reset;
   logic [31:0] rom  [0:63];
   logic [7:0]  dmem [0:511] = '{default: 8'h00};
   logic [8:0]  da;
   bus_ev_t     bus_q [$];
   logic [31:0] pc_q  [$];
   int          compared   = 0;
   int          mismatched = 0;
   bit          done       = 1'b0;

   riscv_core_if bus ();

   riscv_core #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction ROM and byte-addressed data RAM models.
   assign bus.instruction_data = rom[bus.instruction_address[7:2]];
   assign da = bus.data_address[8:0];
   assign bus.data_in = {dmem[da + 9'd3], dmem[da + 9'd2], dmem[da + 9'd1], dmem[da]};

   always @(posedge clock) begin
      if (bus.data_write) begin
         for (int k = 0; k < 4; k++) begin
            if (k < ((bus.data_width == 2'd0) ? 1 : (bus.data_width == 2'd1) ? 2 : 4))
               dmem[da + 9'(k)] <= bus.data_out[8*k +: 8];
         end
      end
   end

   // Instruction encoders.
   function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, int op);
      return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
   endfunction
   function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction
   function automatic logic [31:0] s_t(int imm, int rs2, int rs1, int f3);
      logic [11:0] m = 12'(imm);
      return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
      logic [12:0] m = 13'(imm);
      return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
   endfunction
   function automatic logic [31:0] u_t(int imm, int rd, int op);
      return {20'(imm), 5'(rd), 7'(op)};
   endfunction
   function automatic logic [31:0] j_t(int imm, int rd);
      logic [20:0] m = 21'(imm);
      return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6F};
   endfunction

   task automatic fill_nops();
      for (int i = 0; i < 64; i++) rom[i] = NOP;
   endtask

   task automatic push_pcs(logic [31:0] start, int count);
      for (int i = 0; i < count; i++) pc_q.push_back(start + 32'(4 * i));
   endtask

   task automatic exp_w(logic [31:0] addr, logic [1:0] width, logic [31:0] data);
      bus_ev_t ev;
      ev.is_write = 1'b1; ev.addr = addr; ev.width = width; ev.data = data;
      bus_q.push_back(ev);
   endtask

   task automatic exp_r(logic [31:0] addr, logic [1:0] width);
      bus_ev_t ev;
      ev.is_write = 1'b0; ev.addr = addr; ev.width = width; ev.data = '0;
      bus_q.push_back(ev);
   endtask

   // Two reset edges (PC checked after the first), then release.
   task automatic reset_release();
      reset = 1'b0;
      @(posedge clock); #1;
      pc_q.push_back(32'h0);
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   // Execute n instructions, then hold reset so the next one is discarded.
   task automatic run(int n);
      repeat (n) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic ctl(logic [31:0] ins, logic [31:0] target, bit relinks);
      fill_nops();
      rom[0] = i_t(32'h40, 0, 0, 5, 32'h13);
      rom[6] = s_t(32'h80, 1, 0, 2);
      rom[8] = ins;
      reset_release();
      push_pcs(32'h0, 9);
      pc_q.push_back(target);
      pc_q.push_back(target + 32'd4);
      exp_w(32'h80, 2'd2, 32'h0);
      if (relinks) exp_w(32'h80, 2'd2, 32'h24);
      run(11);
   endtask

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // Monitor: compares every cycle's PC and each bus strobe against the queues.
   initial begin
      bus_ev_t ev;
      while (!done) begin
         @(negedge clock);
         if (pc_q.size() > 0) check("pc", bus.instruction_address, pc_q.pop_front());
         check("rd_wr_exclusive", {31'b0, bus.data_read & bus.data_write}, 32'd0);
         if (bus.data_read || bus.data_write) begin
            if (bus_q.size() == 0) begin
               check("spurious_strobe", {30'b0, bus.data_read, bus.data_write}, 32'd0);
            end else begin
               ev = bus_q.pop_front();
               check("bus_kind", {31'b0, bus.data_write}, {31'b0, ev.is_write});
               check("bus_addr", bus.data_address, ev.addr);
               check("bus_width", 32'(bus.data_width), 32'(ev.width));
               if (ev.is_write) check("bus_data", bus.data_out, ev.data);
            end
         end
      end
      check("pc_left", 32'(pc_q.size()), 32'd0);
      check("bus_left", 32'(bus_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Stimulus.
   initial begin
      reset = 1'b0;

      // ALU, x0 handling, registers zero after reset.
      fill_nops();
      rom[0]  = s_t(0, 5, 0, 2);
      rom[1]  = i_t(-1, 0, 0, 1, 32'h13);
      rom[2]  = i_t(28, 1, 5, 2, 32'h13);
      rom[3]  = i_t(32'h400 + 28, 1, 5, 3, 32'h13);
      rom[4]  = r_t(0, 1, 0, 3, 4);
      rom[5]  = i_t(5, 0, 0, 0, 32'h13);
      rom[6]  = r_t(32'h20, 1, 0, 0, 6);
      rom[7]  = r_t(0, 0, 1, 2, 7);
      rom[8]  = r_t(0, 2, 4, 1, 8);
      rom[9]  = i_t(32'hF0, 1, 4, 9, 32'h13);
      rom[10] = r_t(0, 4, 8, 5, 10);
      rom[11] = r_t(0, 8, 2, 0, 11);
      rom[12] = s_t(32'h10, 1, 0, 2);
      rom[13] = s_t(32'h14, 2, 0, 2);
      rom[14] = s_t(32'h18, 3, 0, 2);
      rom[15] = s_t(32'h1C, 4, 0, 2);
      rom[16] = s_t(32'h20, 0, 0, 2);
      rom[17] = s_t(32'h24, 6, 0, 2);
      rom[18] = s_t(32'h28, 7, 0, 2);
      rom[19] = s_t(32'h2C, 8, 0, 2);
      rom[20] = s_t(32'h30, 9, 0, 2);
      rom[21] = s_t(32'h34, 10, 0, 2);
      rom[22] = s_t(32'h38, 11, 0, 2);
      reset_release();
      push_pcs(32'h0, 23);
      exp_w(32'h00, 2'd2, 32'h0000_0000);
      exp_w(32'h10, 2'd2, 32'hFFFF_FFFF);
      exp_w(32'h14, 2'd2, 32'h0000_000F);
      exp_w(32'h18, 2'd2, 32'hFFFF_FFFF);
      exp_w(32'h1C, 2'd2, 32'h0000_0001);
      exp_w(32'h20, 2'd2, 32'h0000_0000);
      exp_w(32'h24, 2'd2, 32'h0000_0001);
      exp_w(32'h28, 2'd2, 32'h0000_0001);
      exp_w(32'h2C, 2'd2, 32'h0000_8000);
      exp_w(32'h30, 2'd2, 32'hFFFF_FF0F);
      exp_w(32'h34, 2'd2, 32'h0000_4000);
      exp_w(32'h38, 2'd2, 32'h0000_800F);
      run(23);

      // Byte/halfword/word stores and loads with sign and zero extension.
      fill_nops();
      rom[0]  = i_t(32'h100, 0, 0, 1, 32'h13);
      rom[1]  = i_t(32'h80, 0, 0, 2, 32'h13);
      rom[2]  = s_t(1, 2, 1, 0);
      rom[3]  = i_t(1, 1, 0, 3, 32'h03);
      rom[4]  = i_t(1, 1, 4, 4, 32'h03);
      rom[5]  = s_t(32'h10, 3, 1, 2);
      rom[6]  = s_t(32'h14, 4, 1, 2);
      rom[7]  = u_t(8, 5, 32'h37);
      rom[8]  = i_t(1, 5, 0, 5, 32'h13);
      rom[9]  = s_t(32'h20, 5, 1, 1);
      rom[10] = i_t(32'h20, 1, 1, 6, 32'h03);
      rom[11] = i_t(32'h20, 1, 5, 7, 32'h03);
      rom[12] = s_t(32'h24, 6, 1, 2);
      rom[13] = s_t(32'h28, 7, 1, 2);
      rom[14] = s_t(8, 2, 1, 2);
      rom[15] = i_t(32'h24, 1, 2, 8, 32'h03);
      rom[16] = s_t(32'h2C, 8, 1, 2);
      reset_release();
      push_pcs(32'h0, 17);
      exp_w(32'h101, 2'd0, 32'h0000_0080);
      exp_r(32'h101, 2'd0);
      exp_r(32'h101, 2'd0);
      exp_w(32'h110, 2'd2, 32'hFFFF_FF80);
      exp_w(32'h114, 2'd2, 32'h0000_0080);
      exp_w(32'h120, 2'd1, 32'h0000_8001);
      exp_r(32'h120, 2'd1);
      exp_r(32'h120, 2'd1);
      exp_w(32'h124, 2'd2, 32'hFFFF_8001);
      exp_w(32'h128, 2'd2, 32'h0000_8001);
      exp_w(32'h108, 2'd2, 32'h0000_0080);
      exp_r(32'h124, 2'd2);
      exp_w(32'h12C, 2'd2, 32'hFFFF_8001);
      run(17);

      // Control flow from PC 0x20 (x5 = 0x40).
      ctl(b_t(16, 0, 0, 0),   32'h30, 1'b0);
      ctl(b_t(16, 0, 0, 1),   32'h24, 1'b0);
      ctl(j_t(-8, 1),         32'h18, 1'b1);
      ctl(i_t(3, 5, 0, 0, 32'h67), 32'h42, 1'b0);
      ctl(b_t(16, 5, 0, 6),   32'h30, 1'b0);
      ctl(b_t(16, 5, 0, 5),   32'h24, 1'b0);
      ctl(b_t(-16, 0, 5, 7),  32'h10, 1'b0);

      // LUI, AUIPC, unknown opcode as NOP, reset mid-program.
      fill_nops();
      rom[0] = u_t(32'h12345, 1, 32'h37);
      rom[4] = u_t(1, 2, 32'h17);
      rom[5] = 32'h0000_007F;
      rom[6] = s_t(32'h40, 1, 0, 2);
      rom[7] = s_t(32'h44, 2, 0, 2);
      rom[8] = i_t(7, 0, 0, 3, 32'h13);
      rom[9] = s_t(32'h48, 3, 0, 2);
      reset_release();
      push_pcs(32'h0, 10);
      exp_w(32'h40, 2'd2, 32'h1234_5000);
      exp_w(32'h44, 2'd2, 32'h0000_1010);
      repeat (9) @(posedge clock);
      #1 reset = 1'b0;
      pc_q.push_back(32'h0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      done = 1'b1;
   end

endmodule
